// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and data-memory freeze control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt / flush_cnt / wait_cnt performance counters.
module hazard_ctrl #(
  parameter int REG_W    = 5,
`ifdef HAZARD_PERF_CNT_EN
  parameter int CNT_W    = 16,
`endif
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_memread,
  input  logic [REG_W-1:0] IDEX_rt,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic             IFID_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             pc_replay,
  output logic             IFID_write,
  output logic             IFflush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
`ifdef HAZARD_PERF_CNT_EN
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`else
  output logic             mem_timeout
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              timeout_reg, timeout_next;
  logic              lu, mw;

  assign mw = dmem_req && !dmem_ready;
  assign lu = IDEX_memread && (IDEX_rt != '0) &&
              ((IDEX_rt == IFID_rs) || (IFID_uses_rt && (IDEX_rt == IFID_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    timeout_next = timeout_reg;
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFflush      = 1'b0;
    IDEX_bubble  = 1'b0;
    pipe_freeze  = 1'b0;
    pc_replay    = 1'b0;
    case (state_reg)
      MEM_WAIT: begin
        if (mw) begin
          PC_write    = 1'b0;
          pipe_freeze = 1'b1;
          if (wait_reg != WAIT_W'(MAX_WAIT))
            wait_next = wait_reg + 1'b1;
          if (wait_next == WAIT_W'(MAX_WAIT))
            timeout_next = 1'b1;
        end else begin
          state_next = RUN;
          wait_next  = '0;
        end
      end
      default: begin
        // ID holds a bubble in LU_STALL and FLUSH, so only RUN looks at branch/lu.
        IDEX_bubble = (state_reg == FLUSH);
        state_next  = RUN;
        if (mw) begin
          state_next  = MEM_WAIT;
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          pipe_freeze = 1'b1;
          pc_replay   = 1'b1;
          IDEX_bubble = 1'b0;
        end else if (state_reg == RUN) begin
          if (branch_taken) begin
            IFflush    = 1'b1;
            state_next = FLUSH;
          end else if (lu) begin
            IDEX_bubble = 1'b1;
            IFID_write  = 1'b0;
            pc_replay   = 1'b1;
            state_next  = LU_STALL;
          end
        end
      end
    endcase
    if (!rst) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFflush     = 1'b0;
      IDEX_bubble = 1'b1;
      pipe_freeze = 1'b0;
      pc_replay   = 1'b0;
    end
  end

  assign mem_timeout = timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [2:0] perf_inc;
  assign perf_inc = {state_reg == MEM_WAIT, state_next == FLUSH, state_next == LU_STALL};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        cnt_reg <= '0;
      else if (perf_inc[gi] && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = g_perf[0].cnt_reg;
  assign flush_cnt = g_perf[1].cnt_reg;
  assign wait_cnt  = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: literal checks at key points plus a per-cycle
// comparison against a slot/wait-tracking model of the hazard rules.
module tb_hazard_ctrl;
  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic             IDEX_memread = 1'b0;
  logic [REG_W-1:0] IDEX_rt = '0, IFID_rs = '0, IFID_rt = '0;
  logic             IFID_uses_rt = 1'b0, branch_taken = 1'b0;
  logic             dmem_req = 1'b0, dmem_ready = 1'b0;
  logic PC_write, pc_replay, IFID_write, IFflush, IDEX_bubble, pipe_freeze, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .IDEX_memread(IDEX_memread), .IDEX_rt(IDEX_rt),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .pc_replay(pc_replay), .IFID_write(IFID_write),
    .IFflush(IFflush), .IDEX_bubble(IDEX_bubble), .pipe_freeze(pipe_freeze),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Model: which slot follows the current cycle, plus the wait length and sticky timeout.
  bit in_wait = 1'b0, stall_slot = 1'b0, flush_slot = 1'b0, timeout_m = 1'b0;
  int wait_cycles = 0;

  function automatic bit m_mw();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit m_lu();
    return IDEX_memread && (IDEX_rt != 5'd0) &&
           ((IDEX_rt == IFID_rs) || (IFID_uses_rt && (IDEX_rt == IFID_rt)));
  endfunction

  // Returns {PC_write, pc_replay, IFID_write, IFflush, IDEX_bubble, pipe_freeze}.
  function automatic logic [5:0] expect_ctl();
    if (!rst)                   return 6'b000010;
    if (m_mw())                 return in_wait ? 6'b001001 : 6'b010001;
    if (in_wait || stall_slot)  return 6'b101000;
    if (flush_slot)             return 6'b101010;
    if (branch_taken)           return 6'b101100;
    if (m_lu())                 return 6'b110010;
    return 6'b101000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wait <= 1'b0; stall_slot <= 1'b0; flush_slot <= 1'b0;
      timeout_m <= 1'b0; wait_cycles <= 0;
    end else if (in_wait) begin
      if (m_mw()) begin
        if (wait_cycles < MAX_WAIT) wait_cycles <= wait_cycles + 1;
        if (wait_cycles + 1 >= MAX_WAIT) timeout_m <= 1'b1;
      end else begin
        in_wait <= 1'b0;
        wait_cycles <= 0;
      end
    end else begin
      in_wait    <= m_mw();
      flush_slot <= !m_mw() && !(stall_slot || flush_slot) && branch_taken;
      stall_slot <= !m_mw() && !(stall_slot || flush_slot) && !branch_taken && m_lu();
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    e = expect_ctl();
    chk("cyc_pc_write",    PC_write,    e[5]);
    chk("cyc_pc_replay",   pc_replay,   e[4]);
    chk("cyc_ifid_write",  IFID_write,  e[3]);
    chk("cyc_ifflush",     IFflush,     e[2]);
    chk("cyc_idex_bubble", IDEX_bubble, e[1]);
    chk("cyc_pipe_freeze", pipe_freeze, e[0]);
    chk("cyc_mem_timeout", mem_timeout, timeout_m);
  end

  // Apply one cycle of inputs just after the edge; literal checks follow at edge+4.
  task automatic step(input bit mr, input logic [4:0] xrt, input logic [4:0] rs,
                      input logic [4:0] rt, input bit urt, input bit br,
                      input bit req, input bit rdy);
    @(posedge clk); #1;
    IDEX_memread = mr; IDEX_rt = xrt; IFID_rs = rs; IFID_rt = rt;
    IFID_uses_rt = urt; branch_taken = br; dmem_req = req; dmem_ready = rdy;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #3;
    chk("rst_bubble", IDEX_bubble, 1'b1);
    chk("rst_pc_write", PC_write, 1'b0);
    chk("rst_ifid_write", IFID_write, 1'b0);
    chk("rst_timeout", mem_timeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (wait_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_wait_cnt: got %0d expected 0", wait_cnt); end
`endif
    @(posedge clk); @(posedge clk); #1; rst = 1'b1; #3;
    chk("run_pc_write", PC_write, 1'b1);
    chk("run_ifid_write", IFID_write, 1'b1);

    step(1, 5, 5, 0, 0, 0, 0, 0);
    chk("lu_rs_bubble", IDEX_bubble, 1'b1);
    chk("lu_rs_ifid_write", IFID_write, 1'b0);
    chk("lu_rs_replay", pc_replay, 1'b1);
    chk("lu_rs_pc_write", PC_write, 1'b1);
    idle();
    chk("lu_after_bubble", IDEX_bubble, 1'b0);
    chk("lu_after_ifid_write", IFID_write, 1'b1);
    step(1, 7, 3, 7, 1, 0, 0, 0);
    chk("lu_rt_bubble", IDEX_bubble, 1'b1);
    idle();
    step(1, 7, 3, 7, 0, 0, 0, 0);
    chk("lu_rt_unused_bubble", IDEX_bubble, 1'b0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    chk("r0_pc_write", PC_write, 1'b1);
    chk("r0_ifid_write", IFID_write, 1'b1);

    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("br_ifflush", IFflush, 1'b1);
    idle();
    chk("br_next_bubble", IDEX_bubble, 1'b1);
    chk("br_next_ifflush", IFflush, 1'b0);
    idle();
    step(1, 5, 5, 0, 0, 1, 0, 0);
    chk("br_lu_ifflush", IFflush, 1'b1);
    chk("br_lu_replay", pc_replay, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 1, 0);
      chk("mw_br_freeze", pipe_freeze, 1'b1);
      chk("mw_br_ifflush", IFflush, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("mw_exit_freeze", pipe_freeze, 1'b0);
    chk("mw_exit_pc_write", PC_write, 1'b1);
    idle();

    for (int i = 0; i < MAX_WAIT; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("to_15_not_set", mem_timeout, 1'b0);
    idle();
    for (int i = 0; i < MAX_WAIT + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("to_16_set", mem_timeout, 1'b1);
    idle(); idle();
    chk("to_sticky", mem_timeout, 1'b1);

    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("mw_pre_rst_freeze", pipe_freeze, 1'b1);
    #2; rst = 1'b0; #1;
    chk("async_rst_freeze", pipe_freeze, 1'b0);
    chk("async_rst_bubble", IDEX_bubble, 1'b1);
    chk("async_rst_pc_write", PC_write, 1'b0);
    chk("async_rst_timeout", mem_timeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (wait_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_wait_cnt: got %0d expected 0", wait_cnt); end
`endif
    dmem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b1; #3;
    chk("mw_rst_no_residual", pipe_freeze, 1'b0);
    chk("mw_rst_pc_write", PC_write, 1'b1);

    step(1, 9, 9, 0, 0, 0, 0, 0);
    idle();
    #2; rst = 1'b0; #1;
    chk("lu_rst_bubble", IDEX_bubble, 1'b1);
    @(posedge clk); #1; rst = 1'b1; branch_taken = 1'b1; #3;
    chk("lu_rst_branch_seen", IFflush, 1'b1);
    idle();
    chk("lu_rst_flush_bubble", IDEX_bubble, 1'b1);
    idle();
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
